bip_debug_sequencer: RTL and testbench
======================================

Name: bip_debug_sequencer

Overview:
Run/step/halt sequencer for the BIP core, placed between the host debug link (UART command decoder) and the CPU control path.
- Drives CPU_EN, the clock-enable for PC, opcode and operand registers.
- Detects the HALT opcode.
- Owns the data-RAM port whenever the CPU is stalled, and uses it to stream a memory dump back to the host.

Parameters:
ADDR_W, 11, data-RAM address width (matches PC/operand width)
DATA_W, 16, data-RAM word width
HALT_OPCODE, 5'b00000, opcode that stops execution
DUMP_DEPTH, 2048, number of words streamed by a dump (1..2**ADDR_W)

Ports:
CLK  in  1  system clock
RESET  in  1  reset
CMD_VALID  in  1  host command valid
CMD_READY  out  1  command accepted when VALID&&READY
CMD  in  2  00 RUN, 01 STEP, 10 HALT, 11 DUMP
OPCODE  in  5  opcode currently registered in CPU control
CPU_ADDR  in  ADDR_W  CPU data-RAM address (operand)
CPU_RD_RAM  in  1  CPU RAM read request
CPU_WR_RAM  in  1  CPU RAM write request
CPU_EN  out  1  CPU advance enable
RAM_ADDR  out  ADDR_W  muxed RAM address
RAM_RD  out  1  muxed RAM read strobe
RAM_WR  out  1  muxed RAM write strobe
RAM_RDATA  in  DATA_W  RAM read data, 1-cycle synchronous latency
DUMP_VALID  out  1  dump word valid
DUMP_READY  in  1  host accepts dump word
DUMP_DATA  out  DATA_W  dump word
HALTED  out  1  sticky: HALT opcode executed
CYCLE_CNT  out  32  executed-cycle count (see Optional Feature)

Behaviour:
- Reset (already decided): one clock, CLK; reset RESET is synchronous and active-high.
- On reset: state IDLE; CPU_EN=0, CMD_READY=1, DUMP_VALID=0, DUMP_DATA=0, HALTED=0, RAM_RD=0, RAM_WR=0, RAM_ADDR=0, dump address counter=0. A reset mid-RUN or mid-DUMP aborts at the next edge.
- States: IDLE, RUN, STEP, DUMP_RD, DUMP_WAIT.
- IDLE (CMD_READY=1, CPU_EN=0):
  - RUN -> RUN; clears HALTED.
  - STEP -> STEP; clears HALTED.
  - DUMP -> DUMP_RD with address counter=0.
  - HALT -> no effect.
- RUN (CMD_READY=1, CPU_EN=1 every cycle):
  - OPCODE==HALT_OPCODE -> IDLE, HALTED=1.
  - Accepted HALT cmd -> IDLE, HALTED unchanged.
  - Other commands are accepted and ignored.
  - Halt opcode and HALT cmd in the same cycle -> single transition to IDLE, HALTED=1.
- STEP (CMD_READY=0):
  - CPU_EN=1 for exactly one cycle, then IDLE.
  - If OPCODE==HALT_OPCODE in that cycle, HALTED=1.
- DUMP_RD (CMD_READY=0, CPU_EN=0):
  - Drive RAM_RD=1 and RAM_ADDR=counter for one cycle -> DUMP_WAIT.
- DUMP_WAIT:
  - On entry, latch RAM_RDATA into DUMP_DATA and assert DUMP_VALID.
  - Hold DUMP_DATA and DUMP_VALID stable until DUMP_READY.
  - On handshake: if counter==DUMP_DEPTH-1 -> IDLE with counter=0; else counter+1 -> DUMP_RD.
  - Counter never wraps.
  - Throughput is at most 1 word per 2 cycles.
- RAM mux:
  - CPU_EN=1: RAM_ADDR/RD/WR follow the CPU inputs combinationally.
  - DUMP_RD: sequencer drives the port.
  - Otherwise: RAM_RD=RAM_WR=0, RAM_ADDR=0.
  - RAM_WR is never asserted by the sequencer.
- CPU RAM requests while CPU_EN=0 are ignored, not queued.

Optional Feature:
BIP_CYCLE_COUNT_EN
- Defined: CYCLE_CNT is a 32-bit register. It increments on every cycle with CPU_EN=1, saturates at 32'hFFFFFFFF, and is cleared only by RESET.
- Undefined: no counter register; CYCLE_CNT is tied to 0.

Decomposition:
- Shared package bip_pkg holds:
  - command encodings CMD_RUN/STEP/HALT/DUMP
  - state encoding typedef
  - OPC_HLT constant
  - default widths ADDR_W/DATA_W
- One natural sub-module: bip_dump_streamer, containing DUMP_RD/DUMP_WAIT, the address counter and the valid/ready output register. It exposes start and done to the main FSM.

Test Plan:
1. Reset, then STEP cmd with OPCODE=5'h01 -> CPU_EN high exactly 1 cycle; CMD_READY low that cycle; back to IDLE; HALTED=0.
2. RUN cmd, OPCODE nonzero for 10 cycles, then OPCODE=0 -> CPU_EN high 11 cycles, low the cycle after; HALTED=1; CYCLE_CNT=11 with macro, 0 without.
3. RUN, then HALT cmd on the same cycle OPCODE=0 -> single IDLE transition; HALTED=1; no extra CPU_EN pulse.
4. DUMP with DUMP_DEPTH=4, RAM preloaded 0xA0..0xA3, DUMP_READY toggling 1-0-1 -> DUMP_DATA sequence 0xA0,0xA1,0xA2,0xA3; data held while READY=0; RAM_WR never high; return to IDLE.
5. RESET asserted mid-DUMP with DUMP_VALID=1 -> next edge DUMP_VALID=0, state IDLE, counter=0; a new DUMP restarts at address 0.
6. CPU_RD_RAM=1, CPU_ADDR=0x123 while IDLE -> RAM_RD=0, RAM_ADDR=0; same inputs during RUN -> RAM_RD=1, RAM_ADDR=0x123.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP debug sequencer slice.
// Holds host command encodings, sequencer state encoding, the HALT opcode
// and the default data-RAM address/data widths.
package bip_pkg;

  localparam int BIP_ADDR_W = 11;
  localparam int BIP_DATA_W = 16;

  localparam logic [4:0] OPC_HLT = 5'b00000;

  typedef enum logic [1:0] {
    CMD_RUN  = 2'b00,
    CMD_STEP = 2'b01,
    CMD_HALT = 2'b10,
    CMD_DUMP = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_DUMP_RD,
    ST_DUMP_WAIT
  } state_t;

endpackage

// File: rtl/bip_dump_streamer.sv
// Memory-dump streamer: reads DUMP_DEPTH words from the data RAM starting at
// address 0 and presents each one on a valid/ready output register.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               pulse: begin a dump at address 0
//   done                pulse: final word handshaken this cycle
//   ram_rd, ram_addr    read request toward the RAM mux
//   ram_rdata           RAM read data (1-cycle synchronous latency)
//   dump_valid/ready    output handshake
//   dump_data           registered dump word
module bip_dump_streamer
  import bip_pkg::*;
#(
  parameter int ADDR_W     = BIP_ADDR_W,
  parameter int DATA_W     = BIP_DATA_W,
  parameter int DUMP_DEPTH = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              last;

  assign last     = (addr == LAST_ADDR);
  assign ram_rd   = (state == ST_DUMP_RD);
  assign ram_addr = addr;
  assign done     = (state == ST_DUMP_WAIT) && dump_valid && dump_ready && last;

  // The RAM word appears on ram_rdata during the first DUMP_WAIT cycle, so
  // that cycle captures it; dump_valid low inside DUMP_WAIT marks that phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      addr       <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_DUMP_RD;
            addr  <= '0;
          end
        end
        ST_DUMP_RD: state <= ST_DUMP_WAIT;
        ST_DUMP_WAIT: begin
          if (!dump_valid) begin
            dump_valid <= 1'b1;
            dump_data  <= ram_rdata;
          end else if (dump_ready) begin
            dump_valid <= 1'b0;
            if (last) begin
              state <= ST_IDLE;
              addr  <= '0;
            end else begin
              state <= ST_DUMP_RD;
              addr  <= addr + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bip_debug_sequencer.sv
// Run/step/halt sequencer between the host debug link and the BIP CPU.
// Drives CPU_EN, detects the HALT opcode, and owns the data-RAM port while
// the CPU is stalled to stream memory dumps to the host.
// Ports:
//   CLK, RESET                    clock, synchronous active-high reset
//   CMD_VALID/CMD_READY/CMD       host command handshake (RUN/STEP/HALT/DUMP)
//   OPCODE                        opcode registered in CPU control
//   CPU_ADDR/CPU_RD_RAM/CPU_WR_RAM CPU data-RAM request
//   CPU_EN                        CPU advance enable
//   RAM_ADDR/RAM_RD/RAM_WR        muxed RAM port, RAM_RDATA read data
//   DUMP_VALID/DUMP_READY/DUMP_DATA dump word stream
//   HALTED                        sticky HALT-opcode flag
//   CYCLE_CNT                     executed-cycle count
// Optional macro BIP_CYCLE_COUNT_EN: when defined CYCLE_CNT is a saturating
// count of CPU_EN cycles; otherwise it is tied to zero.
module bip_debug_sequencer
  import bip_pkg::*;
#(
  parameter int         ADDR_W      = BIP_ADDR_W,
  parameter int         DATA_W      = BIP_DATA_W,
  parameter logic [4:0] HALT_OPCODE = OPC_HLT,
  parameter int         DUMP_DEPTH  = 2048
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD,
  input  logic [4:0]        OPCODE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic              CPU_RD_RAM,
  input  logic              CPU_WR_RAM,
  output logic              CPU_EN,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_RD,
  output logic              RAM_WR,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic              DUMP_VALID,
  input  logic              DUMP_READY,
  output logic [DATA_W-1:0] DUMP_DATA,
  output logic              HALTED,
  output logic [31:0]       CYCLE_CNT
);

  state_t            state;
  cmd_t              cmd;
  logic              cmd_fire;
  logic              is_halt_op;
  logic              dump_start;
  logic              dump_done;
  logic              dump_rd;
  logic [ADDR_W-1:0] dump_addr;

  assign cmd        = cmd_t'(CMD);
  assign cmd_fire   = CMD_VALID && CMD_READY;
  assign is_halt_op = (OPCODE == HALT_OPCODE);
  assign dump_start = (state == ST_IDLE) && cmd_fire && (cmd == CMD_DUMP);

  // The main FSM parks in ST_DUMP_RD for the whole dump; the streamer owns
  // the finer DUMP_RD/DUMP_WAIT sequencing and reports completion via done.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      CPU_EN    <= 1'b0;
      CMD_READY <= 1'b1;
      HALTED    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            unique case (cmd)
              CMD_RUN: begin
                state  <= ST_RUN;
                CPU_EN <= 1'b1;
                HALTED <= 1'b0;
              end
              CMD_STEP: begin
                state     <= ST_STEP;
                CPU_EN    <= 1'b1;
                CMD_READY <= 1'b0;
                HALTED    <= 1'b0;
              end
              CMD_DUMP: begin
                state     <= ST_DUMP_RD;
                CMD_READY <= 1'b0;
              end
              CMD_HALT: ;
            endcase
          end
        end
        ST_RUN: begin
          // HALT opcode wins over a simultaneous HALT command only in that it
          // also sets HALTED; both produce the same single exit to IDLE.
          if (is_halt_op) begin
            state  <= ST_IDLE;
            CPU_EN <= 1'b0;
            HALTED <= 1'b1;
          end else if (cmd_fire && (cmd == CMD_HALT)) begin
            state  <= ST_IDLE;
            CPU_EN <= 1'b0;
          end
        end
        ST_STEP: begin
          state     <= ST_IDLE;
          CPU_EN    <= 1'b0;
          CMD_READY <= 1'b1;
          if (is_halt_op) HALTED <= 1'b1;
        end
        ST_DUMP_RD: begin
          if (dump_done) begin
            state     <= ST_IDLE;
            CMD_READY <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          CPU_EN    <= 1'b0;
          CMD_READY <= 1'b1;
        end
      endcase
    end
  end

  bip_dump_streamer #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DUMP_DEPTH (DUMP_DEPTH)
  ) u_streamer (
    .clk        (CLK),
    .reset      (RESET),
    .start      (dump_start),
    .done       (dump_done),
    .ram_rd     (dump_rd),
    .ram_addr   (dump_addr),
    .ram_rdata  (RAM_RDATA),
    .dump_valid (DUMP_VALID),
    .dump_ready (DUMP_READY),
    .dump_data  (DUMP_DATA)
  );

  always_comb begin
    RAM_ADDR = '0;
    RAM_RD   = 1'b0;
    RAM_WR   = 1'b0;
    if (CPU_EN) begin
      RAM_ADDR = CPU_ADDR;
      RAM_RD   = CPU_RD_RAM;
      RAM_WR   = CPU_WR_RAM;
    end else if (dump_rd) begin
      RAM_ADDR = dump_addr;
      RAM_RD   = 1'b1;
    end
  end

`ifdef BIP_CYCLE_COUNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cycle_cnt <= '0;
    end else if (CPU_EN && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign CYCLE_CNT = cycle_cnt;
`else
  assign CYCLE_CNT = '0;
`endif

endmodule

// File: tb/tb_bip_debug_sequencer.sv
// Directed self-checking bench for bip_debug_sequencer (DUMP_DEPTH=4).
module tb_bip_debug_sequencer;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

`ifdef BIP_CYCLE_COUNT_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESET;
  logic              CMD_VALID;
  logic              CMD_READY;
  logic [1:0]        CMD;
  logic [4:0]        OPCODE;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic              CPU_RD_RAM;
  logic              CPU_WR_RAM;
  logic              CPU_EN;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic              RAM_RD;
  logic              RAM_WR;
  logic [DATA_W-1:0] RAM_RDATA;
  logic              DUMP_VALID;
  logic              DUMP_READY;
  logic [DATA_W-1:0] DUMP_DATA;
  logic              HALTED;
  logic [31:0]       CYCLE_CNT;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              ram_wr_seen;

  always #5 CLK = ~CLK;

  // RAM model: synchronous read with one cycle of latency.
  always @(posedge CLK) begin
    if (RAM_RD) RAM_RDATA <= mem[RAM_ADDR];
    if (RAM_WR) ram_wr_seen <= 1'b1;
  end

  bip_debug_sequencer #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .HALT_OPCODE (5'b00000),
    .DUMP_DEPTH  (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .CMD_VALID  (CMD_VALID),
    .CMD_READY  (CMD_READY),
    .CMD        (CMD),
    .OPCODE     (OPCODE),
    .CPU_ADDR   (CPU_ADDR),
    .CPU_RD_RAM (CPU_RD_RAM),
    .CPU_WR_RAM (CPU_WR_RAM),
    .CPU_EN     (CPU_EN),
    .RAM_ADDR   (RAM_ADDR),
    .RAM_RD     (RAM_RD),
    .RAM_WR     (RAM_WR),
    .RAM_RDATA  (RAM_RDATA),
    .DUMP_VALID (DUMP_VALID),
    .DUMP_READY (DUMP_READY),
    .DUMP_DATA  (DUMP_DATA),
    .HALTED     (HALTED),
    .CYCLE_CNT  (CYCLE_CNT)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] c);
    CMD       = c;
    CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  // Waits a bounded number of cycles for DUMP_VALID; a timeout is a failure.
  task automatic wait_valid(input string tag);
    int n = 0;
    while (DUMP_VALID !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk(tag, 32'(DUMP_VALID), 32'd1);
  endtask

  function automatic logic [31:0] exp_cc(input int n);
    return CC_EN ? 32'(n) : 32'd0;
  endfunction

  initial begin
    ram_wr_seen = 1'b0;
    RAM_RDATA   = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'hDEAD;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h00A0 + 16'(i);

    RESET      = 1'b1;
    CMD_VALID  = 1'b0;
    CMD        = 2'b00;
    OPCODE     = 5'h01;
    CPU_ADDR   = '0;
    CPU_RD_RAM = 1'b0;
    CPU_WR_RAM = 1'b0;
    DUMP_READY = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_cpu_en",     32'(CPU_EN),     32'd0);
    chk("rst_cmd_ready",  32'(CMD_READY),  32'd1);
    chk("rst_dump_valid", 32'(DUMP_VALID), 32'd0);
    chk("rst_dump_data",  32'(DUMP_DATA),  32'd0);
    chk("rst_halted",     32'(HALTED),     32'd0);
    chk("rst_ram_rd",     32'(RAM_RD),     32'd0);
    chk("rst_ram_wr",     32'(RAM_WR),     32'd0);
    chk("rst_ram_addr",   32'(RAM_ADDR),   32'd0);
    chk("rst_cycle_cnt",  CYCLE_CNT,       32'd0);
    RESET = 1'b0;

    // 1: single STEP with non-halt opcode
    OPCODE = 5'h01;
    send_cmd(2'b01);
    chk("step_cpu_en",    32'(CPU_EN),    32'd1);
    chk("step_cmd_ready", 32'(CMD_READY), 32'd0);
    tick();
    chk("step_end_cpu_en",    32'(CPU_EN),    32'd0);
    chk("step_end_cmd_ready", 32'(CMD_READY), 32'd1);
    chk("step_halted",        32'(HALTED),    32'd0);
    chk("step_cycle_cnt",     CYCLE_CNT,      exp_cc(1));
    tick();
    chk("step_no_extra_en", 32'(CPU_EN), 32'd0);

    // 2: RUN for 10 cycles then HALT opcode -> 11 enabled cycles
    do_reset();
    OPCODE = 5'h01;
    send_cmd(2'b00);
    for (int i = 0; i < 10; i++) begin
      chk("run_cpu_en", 32'(CPU_EN), 32'd1);
      tick();
    end
    OPCODE = 5'h00;
    #1;
    chk("run_last_cpu_en", 32'(CPU_EN), 32'd1);
    chk("run_pre_halted",  32'(HALTED), 32'd0);
    tick();
    OPCODE = 5'h01;
    chk("run_stop_cpu_en", 32'(CPU_EN),    32'd0);
    chk("run_halted",      32'(HALTED),    32'd1);
    chk("run_cycle_cnt",   CYCLE_CNT,      exp_cc(11));
    chk("run_cmd_ready",   32'(CMD_READY), 32'd1);

    // 6: CPU RAM request ignored while idle, forwarded while running;
    //    HALT command alone leaves HALTED clear
    CPU_RD_RAM = 1'b1;
    CPU_ADDR   = 11'h123;
    #1;
    chk("idle_ram_rd",   32'(RAM_RD),   32'd0);
    chk("idle_ram_addr", 32'(RAM_ADDR), 32'd0);
    send_cmd(2'b00);
    chk("run_clears_halted", 32'(HALTED),   32'd0);
    chk("run_ram_rd",        32'(RAM_RD),   32'd1);
    chk("run_ram_addr",      32'(RAM_ADDR), 32'h123);
    send_cmd(2'b10);
    chk("haltcmd_cpu_en", 32'(CPU_EN), 32'd0);
    chk("haltcmd_halted", 32'(HALTED), 32'd0);
    chk("haltcmd_ram_rd", 32'(RAM_RD), 32'd0);
    CPU_RD_RAM = 1'b0;
    CPU_ADDR   = '0;

    // 3: HALT command and HALT opcode in the same RUN cycle
    send_cmd(2'b00);
    tick();
    OPCODE    = 5'h00;
    CMD       = 2'b10;
    CMD_VALID = 1'b1;
    #1;
    chk("dual_cpu_en_before", 32'(CPU_EN), 32'd1);
    tick();
    CMD_VALID = 1'b0;
    OPCODE    = 5'h01;
    chk("dual_cpu_en",    32'(CPU_EN),    32'd0);
    chk("dual_halted",    32'(HALTED),    32'd1);
    chk("dual_cmd_ready", 32'(CMD_READY), 32'd1);
    tick();
    chk("dual_no_extra_en", 32'(CPU_EN), 32'd0);

    // 4: four-word dump with DUMP_READY stalls on odd words
    send_cmd(2'b11);
    chk("dump_cmd_ready", 32'(CMD_READY), 32'd0);
    chk("dump_cpu_en",    32'(CPU_EN),    32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      wait_valid("dump_valid");
      chk("dump_data", 32'(DUMP_DATA), 32'h00A0 + 32'(k));
      if (k % 2 == 1) begin
        DUMP_READY = 1'b0;
        tick();
        chk("dump_hold_valid", 32'(DUMP_VALID), 32'd1);
        chk("dump_hold_data",  32'(DUMP_DATA),  32'h00A0 + 32'(k));
      end
      DUMP_READY = 1'b1;
      tick();
      DUMP_READY = 1'b0;
      chk("dump_valid_drop", 32'(DUMP_VALID), 32'd0);
    end
    chk("dump_done_cmd_ready", 32'(CMD_READY), 32'd1);
    tick();
    chk("dump_done_ram_rd", 32'(RAM_RD), 32'd0);
    chk("dump_done_valid",  32'(DUMP_VALID), 32'd0);

    // 5: reset in the middle of a dump, then restart from address 0
    send_cmd(2'b11);
    wait_valid("abort_w0_valid");
    chk("abort_w0_data", 32'(DUMP_DATA), 32'h00A0);
    DUMP_READY = 1'b1;
    tick();
    DUMP_READY = 1'b0;
    wait_valid("abort_w1_valid");
    chk("abort_w1_data", 32'(DUMP_DATA), 32'h00A1);
    do_reset();
    chk("abort_valid",     32'(DUMP_VALID), 32'd0);
    chk("abort_data",      32'(DUMP_DATA),  32'd0);
    chk("abort_cmd_ready", 32'(CMD_READY),  32'd1);
    chk("abort_ram_rd",    32'(RAM_RD),     32'd0);
    chk("abort_halted",    32'(HALTED),     32'd0);
    tick();
    chk("abort_stays_idle", 32'(DUMP_VALID), 32'd0);
    send_cmd(2'b11);
    chk("restart_ram_rd",   32'(RAM_RD),   32'd1);
    chk("restart_ram_addr", 32'(RAM_ADDR), 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      wait_valid("restart_valid");
      chk("restart_data", 32'(DUMP_DATA), 32'h00A0 + 32'(k));
      DUMP_READY = 1'b1;
      tick();
      DUMP_READY = 1'b0;
    end
    chk("restart_done_cmd_ready", 32'(CMD_READY), 32'd1);

    chk("ram_wr_never", 32'(ram_wr_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
